// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the MEM stage and a word-wide data memory.
// Sub-word stores use read-modify-write; loads are extended from the addressed lane.
module mem_access_ctrl #(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        memWriteEnable,
    output logic [31:0] memAddr,
    output logic [31:0] memWriteData,
    input  logic [31:0] memReadData,
    output logic [31:0] PC
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] wbuf_q, wbuf_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  f3_q, f3_d;
    logic        st_q, st_d;

    logic        req_err;
    logic        is_half;
    logic        is_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;

    always_comb begin
        is_half = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);
        is_word = (req_funct3 == 3'b010);
        req_err = 1'b0;
        unique case (req_funct3)
            3'b000, 3'b001, 3'b010: req_err = 1'b0;
            3'b100, 3'b101:         req_err = req_store;
            default:                req_err = 1'b1;
        endcase
        if (CHECK_ALIGN) begin
            if (is_half && req_addr[0])
                req_err = 1'b1;
            if (is_word && (req_addr[1:0] != 2'b00))
                req_err = 1'b1;
        end
    end

    always_comb begin
        ld_byte   = memReadData[{addr_q[1:0], 3'b000} +: 8];
        ld_half   = memReadData[{addr_q[1], 4'b0000} +: 16];
        load_data = 32'd0;
        unique case (f3_q)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b010:  load_data = memReadData;
            3'b100:  load_data = {24'd0, ld_byte};
            3'b101:  load_data = {16'd0, ld_half};
            default: load_data = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wbuf_d  = wbuf_q;
        pc_d    = pc_q;
        f3_d    = f3_q;
        st_d    = st_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    pc_d    = req_pc;
                    f3_d    = req_funct3;
                    st_d    = req_store;
                    if (req_err)
                        state_d = S_ERR;
                    else if (!req_store)
                        state_d = S_LOAD;
                    else if (is_word)
                        state_d = S_WRITE;
                    else
                        state_d = S_MERGE;
                end
            end
            S_LOAD: state_d = S_IDLE;
            S_MERGE: begin
                wbuf_d = memReadData;
                if (f3_q[1:0] == 2'b00)
                    wbuf_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
                else
                    wbuf_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wbuf_q  <= 32'd0;
            pc_q    <= 32'd0;
            f3_q    <= 3'd0;
            st_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wbuf_q  <= wbuf_d;
            pc_q    <= pc_d;
            f3_q    <= f3_d;
            st_q    <= st_d;
        end
    end

    // Ready and write strobe are gated by reset so nothing is taken or written while held.
    assign req_ready      = (state_q == S_IDLE) && rstn;
    assign memWriteEnable = (state_q == S_WRITE) && rstn;
    assign resp_valid     = (state_q == S_LOAD) || (state_q == S_WRITE) ||
                            (state_q == S_ERR);
    assign resp_err       = (state_q == S_ERR);
    assign resp_rdata     = (state_q == S_LOAD) ? load_data : 32'd0;
    assign memAddr        = {addr_q[31:2], 2'b00};
    assign memWriteData   = (st_q && (f3_q == 3'b010)) ? wdata_q : wbuf_q;
    assign PC             = pc_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 1024x32 memory.
// A second instance runs with alignment checking disabled.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, req_pc;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o;

    logic        req_valid_1, req_ready_1;
    logic [2:0]  req_funct3_1;
    logic [31:0] req_addr_1;
    logic        resp_valid_1, resp_err_1;
    logic [31:0] resp_rdata_1;
    logic        mem_we_1;
    logic [31:0] mem_addr_1, mem_wdata_1, mem_rdata_1, pc_o_1;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        poke_en;
    logic [9:0]  poke_a;
    logic [31:0] poke_d;

    int nvec = 0;
    int nerr = 0;
    int lat, wecnt;
    logic [31:0] rd, wdat, wpc;
    logic        er;

    mem_access_ctrl #(.CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata),
        .memWriteEnable(mem_we), .memAddr(mem_addr),
        .memWriteData(mem_wdata), .memReadData(mem_rdata),
        .PC(pc_o)
    );

    mem_access_ctrl #(.CHECK_ALIGN(1'b0)) dut_na (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid_1), .req_ready(req_ready_1),
        .req_store(1'b0), .req_funct3(req_funct3_1),
        .req_addr(req_addr_1), .req_wdata(32'd0), .req_pc(32'd0),
        .resp_valid(resp_valid_1), .resp_err(resp_err_1),
        .resp_rdata(resp_rdata_1),
        .memWriteEnable(mem_we_1), .memAddr(mem_addr_1),
        .memWriteData(mem_wdata_1), .memReadData(mem_rdata_1),
        .PC(pc_o_1)
    );

    assign mem_rdata   = mem[mem_addr[11:2]];
    assign mem_rdata_1 = mem[mem_addr_1[11:2]];

    always @(posedge clk) begin
        if (poke_en)
            mem[poke_a] <= poke_d;
        else if (mem_we)
            mem[mem_addr[11:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int w, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1;
        poke_a  = 10'(w);
        poke_d  = d;
        @(posedge clk);
        #1 poke_en = 1'b0;
        ref_mem[w] = d;
    endtask

    task automatic xact(input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] pc);
        int k;
        lat   = -1;
        wecnt = 0;
        rd    = 32'h5A5A5A5A;
        er    = 1'b0;
        wdat  = 32'd0;
        wpc   = 32'd0;
        k     = 0;
        @(negedge clk);
        while (!req_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_pc     = pc;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (mem_we) begin
                wecnt++;
                wdat = mem_wdata;
                wpc  = pc_o;
            end
            if (resp_valid) begin
                lat = i;
                rd  = resp_rdata;
                er  = resp_err;
                break;
            end
        end
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] exp);
        xact(1'b0, f3, a, 32'd0, 32'h400);
        check({tag, "_lat"}, 32'(lat), 32'd1);
        check({tag, "_err"}, {31'd0, er}, 32'd0);
        check({tag, "_data"}, rd, exp);
    endtask

    task automatic err_chk(input string tag, input logic st,
                           input logic [2:0] f3, input logic [31:0] a);
        xact(st, f3, a, 32'h12345678, 32'h500);
        check({tag, "_lat"}, 32'(lat), 32'd1);
        check({tag, "_err"}, {31'd0, er}, 32'd1);
        check({tag, "_rdata"}, rd, 32'd0);
        check({tag, "_nowr"}, 32'(wecnt), 32'd0);
    endtask

    task automatic na_load(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        req_valid_1  = 1'b1;
        req_funct3_1 = f3;
        req_addr_1   = a;
        @(posedge clk);
        #1 req_valid_1 = 1'b0;
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, resp_valid_1}, 32'd1);
        check({tag, "_err"}, {31'd0, resp_err_1}, 32'd0);
        check({tag, "_data"}, resp_rdata_1, exp);
    endtask

    initial begin
        int w, gap;
        logic st;
        logic [31:0] d;

        poke_en      = 1'b0;
        poke_a       = 10'd0;
        poke_d       = 32'd0;
        rstn         = 1'b0;
        req_valid    = 1'b1;
        req_store    = 1'b0;
        req_funct3   = 3'b010;
        req_addr     = 32'h40;
        req_wdata    = 32'd0;
        req_pc       = 32'h1234;
        req_valid_1  = 1'b0;
        req_funct3_1 = 3'b010;
        req_addr_1   = 32'd0;

        @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_resp", {31'd0, resp_valid}, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_ready2", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        rstn      = 1'b1;
        @(negedge clk);
        check("rst_notaken", mem_addr, 32'd0);
        check("rst_idle", {31'd0, req_ready}, 32'd1);

        poke(4, 32'hDEADBEEF);
        load_chk("lw10", 3'b010, 32'h10, 32'hDEADBEEF);
        load_chk("lb13", 3'b000, 32'h13, 32'hFFFFFFDE);
        load_chk("lbu13", 3'b100, 32'h13, 32'h000000DE);
        load_chk("lhu12", 3'b101, 32'h12, 32'h0000DEAD);
        load_chk("lh12", 3'b001, 32'h12, 32'hFFFFDEAD);
        load_chk("lb10", 3'b000, 32'h10, 32'hFFFFFFEF);

        poke(4, 32'h11223344);
        xact(1'b1, 3'b000, 32'h11, 32'hFFFFFFAA, 32'h100);
        check("sb_lat", 32'(lat), 32'd2);
        check("sb_wecnt", 32'(wecnt), 32'd1);
        check("sb_wdata", wdat, 32'h1122AA44);
        check("sb_pc", wpc, 32'h100);
        check("sb_rdata", rd, 32'd0);
        @(negedge clk);
        check("sb_we_off", {31'd0, mem_we}, 32'd0);
        check("sb_mem", mem[4], 32'h1122AA44);

        poke(4, 32'h11223344);
        xact(1'b1, 3'b001, 32'h12, 32'h0000BEEF, 32'h104);
        check("sh_lat", 32'(lat), 32'd2);
        check("sh_wdata", wdat, 32'hBEEF3344);
        xact(1'b1, 3'b010, 32'h14, 32'hCAFEF00D, 32'h108);
        check("sw_lat", 32'(lat), 32'd1);
        check("sw_wecnt", 32'(wecnt), 32'd1);
        check("sw_wdata", wdat, 32'hCAFEF00D);
        @(negedge clk);
        check("sh_mem", mem[4], 32'hBEEF3344);
        check("sw_mem", mem[5], 32'hCAFEF00D);

        err_chk("lh13", 1'b0, 3'b001, 32'h13);
        err_chk("sw16", 1'b1, 3'b010, 32'h16);
        err_chk("st_f3_100", 1'b1, 3'b100, 32'h10);
        err_chk("ld_f3_011", 1'b0, 3'b011, 32'h10);
        @(negedge clk);
        check("err_mem4", mem[4], 32'hBEEF3344);
        check("err_mem5", mem[5], 32'hCAFEF00D);

        na_load("na_lw13", 3'b010, 32'h13, 32'hBEEF3344);
        na_load("na_lh13", 3'b001, 32'h13, 32'hFFFFBEEF);

        poke(6, 32'h55667788);
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h18;
        req_wdata  = 32'h99;
        req_pc     = 32'h200;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        check("mrg_rst_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        check("mrg_rst_we2", {31'd0, mem_we}, 32'd0);
        check("mrg_rst_resp", {31'd0, resp_valid}, 32'd0);
        check("mrg_rst_addr", mem_addr, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("mrg_rst_idle", {31'd0, req_ready}, 32'd1);
        check("mrg_rst_mem", mem[6], 32'h55667788);

        poke(7, 32'h0BADF00D);
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h1C;
        req_wdata  = 32'hFFFFFFFF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        check("wr_rst_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("wr_rst_mem", mem[7], 32'h0BADF00D);
        check("wr_rst_idle", {31'd0, req_ready}, 32'd1);

        for (int i = 128; i < 144; i++)
            poke(i, $urandom);
        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            st = 1'($urandom_range(0, 1));
            w  = $urandom_range(128, 143);
            d  = $urandom;
            xact(st, 3'b010, 32'(w) << 2, d, 32'h2000 + 32'(i) * 4);
            if (st) begin
                ref_mem[w] = d;
                check("strm_sw_lat", 32'(lat), 32'd1);
            end else begin
                check("strm_lw_data", rd, ref_mem[w]);
            end
        end
        @(negedge clk);
        for (int i = 128; i < 144; i++)
            check("strm_mem", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
